tpu_job_sequencer: RTL

Top-level job controller for the systolic-array front end. On a `start` pulse it clears the data/weight queue array, streams one tile of operands from operand SRAM into it, launches the systolic compute, waits for the queues to drain, allows the array pipeline to flush, and reports `done`. It replaces ad-hoc testbench driving of `read_start`/`compute_start` and adds abort and watchdog handling.

---
 rtl/tpu_job_sequencer.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tpu_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpu_job_sequencer
// Purpose  : Job controller for the systolic-array front end. A start request
//            clears the queue array, streams one tile of operands from the
//            operand SRAM, launches the compute, waits for the queues to drain,
//            flushes the array pipeline and reports completion. Abort and a
//            watchdog on the two externally paced phases return the block to
//            idle without a completion pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   job request, only honoured while idle
//   abort          in   synchronous cancel, honoured in any active state
//   base_addr      in   tile base address, captured when a job is accepted
//   busy           out  high whenever a job is in flight
//   done           out  one-cycle completion pulse
//   error          out  sticky watchdog flag, cleared by the next accepted job
//   sram_addr      out  operand SRAM read address (holds outside the load)
//   sram_rd_en     out  operand SRAM read strobe
//   queue_clr      out  one-cycle clear to the queue array
//   read_start     out  queue array load enable
//   read_done      in   queue array holds the complete tile (level)
//   compute_start  out  queue array read / compute enable
//   read_all_data  in   queues fully drained into the array (level)
//   acc_clear      out  one-cycle PE accumulator clear at compute launch
// All outputs come straight from flops and reflect the state that the
// registered state machine is currently in.
// ============================================================================
module tpu_job_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int ARRAY_SIZE   = 2,
  parameter int ADDR_WIDTH   = 10,
  parameter int LOAD_WORDS   = 2 * ARRAY_SIZE * ARRAY_SIZE,
  parameter int DRAIN_CYCLES = 2 * ARRAY_SIZE,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_rd_en,
  output logic                  queue_clr,
  output logic                  read_start,
  input  logic                  read_done,
  output logic                  compute_start,
  input  logic                  read_all_data,
  output logic                  acc_clear
);

  // --------------------------------------------------------------------------
  // Derived widths and terminal counts
  // --------------------------------------------------------------------------
  localparam int LCNT_W = (LOAD_WORDS   > 1) ? $clog2(LOAD_WORDS)   : 1;
  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WD_W   = 8;

  localparam logic [LCNT_W-1:0] LOAD_LAST  = LCNT_W'(LOAD_WORDS - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);

  // Elaboration-time guard: the watchdog is 8 bits wide and the load and
  // drain counters need at least one step to count.
  if (DATA_WIDTH < 1 || LOAD_WORDS < 2 || DRAIN_CYCLES < 1 ||
      TIMEOUT < 2 || TIMEOUT > 256 || ADDR_WIDTH < 1) begin : g_param_check
    $error("tpu_job_sequencer: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    LOAD      = 3'd2,
    WAIT_LOAD = 3'd3,
    COMPUTE   = 3'd4,
    DRAIN     = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t                state_q,        state_d;
  logic [ADDR_WIDTH-1:0] base_q,         base_d;
  logic [LCNT_W-1:0]     load_cnt_q,     load_cnt_d;
  logic [DCNT_W-1:0]     drain_cnt_q,    drain_cnt_d;
  logic [WD_W-1:0]       wd_cnt_q,       wd_cnt_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q,    sram_addr_d;
  logic                  error_q,        error_d;
  logic                  busy_q,         busy_d;
  logic                  done_q,         done_d;
  logic                  sram_rd_en_q,   sram_rd_en_d;
  logic                  queue_clr_q,    queue_clr_d;
  logic                  read_start_q,   read_start_d;
  logic                  compute_start_q, compute_start_d;
  logic                  acc_clear_q,    acc_clear_d;

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    sram_addr_d = sram_addr_q;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        // start together with abort is treated as a cancelled request
        if (start && !abort) begin
          state_d = CLEAR;
          base_d  = base_addr;
          error_d = 1'b0;
        end
      end

      CLEAR: begin
        state_d     = LOAD;
        load_cnt_d  = '0;
        sram_addr_d = base_q;
      end

      LOAD: begin
        // read_done is deliberately not looked at until the last word is out
        if (load_cnt_q == LOAD_LAST) begin
          state_d  = WAIT_LOAD;
          wd_cnt_d = '0;
        end else begin
          load_cnt_d  = load_cnt_q + 1'b1;
          // wraps naturally at the top of the address space
          sram_addr_d = sram_addr_q + 1'b1;
        end
      end

      WAIT_LOAD: begin
        // Queue progress takes precedence over a watchdog expiring on the
        // same cycle.
        if (read_done) begin
          state_d  = COMPUTE;
          wd_cnt_d = '0;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      COMPUTE: begin
        if (read_all_data) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every other transition, including the watchdog and
    // the step into DONE. Side effects computed above are discarded so the
    // error flag and the SRAM address keep their current values.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      error_d     = error_q;
      sram_addr_d = sram_addr_q;
    end

    // Moore outputs decoded from the state being entered, so the flops
    // present them during the first cycle of that state.
    busy_d          = (state_d != IDLE);
    queue_clr_d     = (state_d == CLEAR);
    sram_rd_en_d    = (state_d == LOAD);
    read_start_d    = (state_d == LOAD) || (state_d == WAIT_LOAD);
    compute_start_d = (state_d == COMPUTE);
    // only on the entry cycle of COMPUTE
    acc_clear_d     = (state_d == COMPUTE) && (state_q != COMPUTE);
    done_d          = (state_d == DONE);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      load_cnt_q      <= '0;
      drain_cnt_q     <= '0;
      wd_cnt_q        <= '0;
      sram_addr_q     <= '0;
      error_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      sram_rd_en_q    <= 1'b0;
      queue_clr_q     <= 1'b0;
      read_start_q    <= 1'b0;
      compute_start_q <= 1'b0;
      acc_clear_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      load_cnt_q      <= load_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      wd_cnt_q        <= wd_cnt_d;
      sram_addr_q     <= sram_addr_d;
      error_q         <= error_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      sram_rd_en_q    <= sram_rd_en_d;
      queue_clr_q     <= queue_clr_d;
      read_start_q    <= read_start_d;
      compute_start_q <= compute_start_d;
      acc_clear_q     <= acc_clear_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign sram_addr     = sram_addr_q;
  assign sram_rd_en    = sram_rd_en_q;
  assign queue_clr     = queue_clr_q;
  assign read_start    = read_start_q;
  assign compute_start = compute_start_q;
  assign acc_clear     = acc_clear_q;

endmodule
`default_nettype wire
